// File: rtl/therm3_to_bin2_enc.sv
// Thermometer-to-binary encoder: 3-bit thermometer code in, 2-bit {A,B} out.
// A 2-entry output buffer absorbs stalls; illegal codes are flagged and counted.
module therm3_to_bin2_enc #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_a,
    output logic             out_b,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    input  logic             clr_err
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [2:0]       head_q, head_d;
    logic [2:0]       tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    logic [1:0] enc_ab;
    logic       enc_err;
    logic [2:0] enc_ent;
    logic       push;
    logic       pop;

    always_comb begin
        enc_ab  = 2'b00;
        enc_err = 1'b0;
        case (in_y)
            3'b000:  enc_ab = 2'b00;
            3'b001:  enc_ab = 2'b01;
            3'b011:  enc_ab = 2'b10;
            3'b111:  enc_ab = 2'b11;
            default: enc_err = 1'b1;
        endcase
    end

    assign enc_ent   = {enc_ab, enc_err};
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // head_q doubles as the output register, so it keeps its value when empty
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            if (count_q == FULL) begin
                head_d = tail_q;
            end else if (push) begin
                head_d = enc_ent;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_d = enc_ent;
            end else begin
                tail_d = enc_ent;
            end
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // clear takes effect before a same-cycle increment
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr_err) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
        if (push && enc_err) begin
            sticky_d = 1'b1;
            if (cnt_d != {CNT_W{1'b1}}) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_a      = head_q[2];
    assign out_b      = head_q[1];
    assign out_err    = head_q[0];
    assign err_cnt    = cnt_q;
    assign err_sticky = sticky_q;

endmodule
